manual_override_panel: RTL and testbench
========================================

// Module: manual_override_panel
// PURPOSE
//  Front-panel command source for the traffic_light_controller manual interface.
//  Debounces three push-buttons, runs an AUTO/MANUAL mode FSM and drives the
//  controller's manual_override / manual_state inputs. Returns to AUTO after an
//  inactivity timeout. Sits between board buttons and traffic_light_controller.
// PARAMETERS
//  DEBOUNCE_CYCLES  1_000_000    consecutive stable cycles before a level is accepted (10 ms @100 MHz)
//  TICK_CYCLES      100_000_000  prescaler period for a 1 s tick
//  TIMEOUT_S        30           idle seconds in MANUAL before auto-return; 0 = timeout disabled
// PORTS
//  clk              in   1  system clock, 100 MHz
//  reset            in   1  asynchronous, active-high
//  btn_mode         in   1  raw button: toggle AUTO<->MANUAL
//  btn_next         in   1  raw button: step manual light state
//  btn_red          in   1  raw button: force MANUAL + red (emergency)
//  manual_override  out  1  1 = controller follows manual_state
//  manual_state     out  2  00 red, 01 yellow, 10 green; 11 never driven
//  idle_secs_left   out  8  seconds remaining before auto-return; 0 in AUTO
// BEHAVIOUR
//  Reset (async): mode=AUTO, manual_override=0, manual_state=00, idle_secs_left=0,
//   all sync/debounce/prescaler state cleared, debounced levels=0.
//  Input path per button: 2-FF synchroniser -> debouncer -> rising-edge press pulse.
//   Debounced level flips only after the synced level has differed from it for
//   DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle clears the count.
//   Press pulse = 1 cycle on debounced 0->1 only; release generates nothing.
//  Latency: raw edge held stable -> outputs change exactly DEBOUNCE_CYCLES+3 clk later.
//  FSM (registered outputs, update the cycle after the press pulse):
//   AUTO:   btn_mode or btn_red -> MANUAL, manual_state=00; btn_next ignored.
//   MANUAL: btn_red  -> stay MANUAL, manual_state=00, timer reload.
//           btn_mode -> AUTO, manual_state=00, idle_secs_left=0.
//           btn_next -> 00->10->01->00 (red->green->yellow->red), timer reload.
//           timeout  -> AUTO, manual_state=00.
//   manual_override=1 exactly when mode=MANUAL.
//  Simultaneous pulses in one cycle: btn_red > btn_mode > btn_next; lower ones dropped.
//  Timer: on MANUAL entry or reload, idle_secs_left=TIMEOUT_S and prescaler cleared.
//   Prescaler counts 0..TICK_CYCLES-1; at wrap idle_secs_left decrements (saturate at 0).
//   Decrement to 0 -> AUTO on the same edge. Press on the wrap cycle wins (reload).
//   TIMEOUT_S=0: no auto-return; idle_secs_left stays 0.
//  Held button: single press only; a new press needs a debounced release first.
//  Bounce shorter than DEBOUNCE_CYCLES: no press, no output change.
//  Reset mid-operation: immediate return to reset values, a held button is
//   re-detected as a new press once debounced after reset release.
// TESTING  (DEBOUNCE_CYCLES=4, TICK_CYCLES=10, TIMEOUT_S=3)
//  1 reset, no buttons 200 cycles -> override=0, state=00, idle_secs_left=0 throughout.
//  2 btn_mode high 20 cycles -> override=1, state=00 exactly 7 cycles after edge, idle=3.
//  3 in MANUAL, three btn_next presses (10 high/10 low) -> state 10, 01, 00; idle reloads to 3.
//  4 in MANUAL, no presses -> idle 3,2,1,0 at 10-cycle steps; override=0 when idle hits 0.
//  5 btn_next glitches of 3 cycles high -> no state change; btn_next in AUTO -> override stays 0.
//  6 btn_red+btn_mode same cycle while state=10 -> state=00, override stays 1;
//    assert reset mid-press -> outputs zero immediately, state 11 never observed.

Source files
------------

// File: rtl/manual_override_panel.sv
// Front-panel command source for the traffic light controller's manual interface.
// Debounces three buttons, runs the AUTO/MANUAL mode FSM and an idle auto-return timer.
module manual_override_panel #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int TICK_CYCLES     = 100_000_000,
    parameter int TIMEOUT_S       = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_next,
    input  logic       btn_red,
    output logic       manual_override,
    output logic [1:0] manual_state,
    output logic [7:0] idle_secs_left
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TK_W-1:0] TK_LAST = TK_W'(TICK_CYCLES - 1);
    localparam logic [7:0] TIMEOUT_RELOAD = 8'(TIMEOUT_S);
    localparam bit TIMER_EN = (TIMEOUT_S != 0);

    localparam int BTN_MODE = 0;
    localparam int BTN_NEXT = 1;
    localparam int BTN_RED  = 2;

    localparam logic [0:0] MODE_AUTO   = 1'b0;
    localparam logic [0:0] MODE_MANUAL = 1'b1;

    localparam logic [1:0] LIGHT_RED    = 2'b00;
    localparam logic [1:0] LIGHT_YELLOW = 2'b01;
    localparam logic [1:0] LIGHT_GREEN  = 2'b10;

    logic [2:0]      btn_raw;
    logic [2:0]      sync1_q;
    logic [2:0]      sync2_q;
    logic [2:0]      deb_q;
    logic [2:0]      deb_d;
    logic [2:0]      deb_prev_q;
    logic [2:0]      press;
    logic [DB_W-1:0] db_cnt_q [3];
    logic [DB_W-1:0] db_cnt_d [3];

    logic [0:0]      mode_q;
    logic [0:0]      mode_d;
    logic [1:0]      light_q;
    logic [1:0]      light_d;
    logic [7:0]      idle_q;
    logic [7:0]      idle_d;
    logic [TK_W-1:0] presc_q;
    logic [TK_W-1:0] presc_d;
    logic            tick;

    assign btn_raw = {btn_red, btn_next, btn_mode};

    // A level is accepted only after disagreeing with the current debounced
    // level for DEBOUNCE_CYCLES consecutive cycles; one agreeing cycle restarts the count.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            deb_d[i]    = deb_q[i];
            db_cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q    <= btn_raw;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    // One-cycle pulse on a debounced press; releases produce nothing.
    assign press = deb_q & ~deb_prev_q;

    assign tick = (presc_q == TK_LAST);

    function automatic logic [1:0] next_light(input logic [1:0] cur);
        case (cur)
            LIGHT_RED:    next_light = LIGHT_GREEN;
            LIGHT_GREEN:  next_light = LIGHT_YELLOW;
            LIGHT_YELLOW: next_light = LIGHT_RED;
            default:      next_light = LIGHT_RED;
        endcase
    endfunction

    always_comb begin
        mode_d  = mode_q;
        light_d = light_q;
        idle_d  = idle_q;
        presc_d = presc_q;
        case (mode_q)
            MODE_AUTO: begin
                presc_d = '0;
                idle_d  = 8'd0;
                light_d = LIGHT_RED;
                if (press[BTN_RED] || press[BTN_MODE]) begin
                    mode_d = MODE_MANUAL;
                    idle_d = TIMER_EN ? TIMEOUT_RELOAD : 8'd0;
                end
            end
            MODE_MANUAL: begin
                // Priority red > mode > next; a press on the tick cycle beats the timeout.
                if (press[BTN_RED]) begin
                    light_d = LIGHT_RED;
                    idle_d  = TIMER_EN ? TIMEOUT_RELOAD : 8'd0;
                    presc_d = '0;
                end else if (press[BTN_MODE]) begin
                    mode_d  = MODE_AUTO;
                    light_d = LIGHT_RED;
                    idle_d  = 8'd0;
                    presc_d = '0;
                end else if (press[BTN_NEXT]) begin
                    light_d = next_light(light_q);
                    idle_d  = TIMER_EN ? TIMEOUT_RELOAD : 8'd0;
                    presc_d = '0;
                end else if (TIMER_EN) begin
                    if (tick) begin
                        presc_d = '0;
                        if (idle_q != 8'd0) begin
                            idle_d = idle_q - 8'd1;
                        end
                        if (idle_q == 8'd1) begin
                            mode_d  = MODE_AUTO;
                            light_d = LIGHT_RED;
                        end
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
            end
            default: begin
                mode_d  = MODE_AUTO;
                light_d = LIGHT_RED;
                idle_d  = 8'd0;
                presc_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q  <= MODE_AUTO;
            light_q <= LIGHT_RED;
            idle_q  <= 8'd0;
            presc_q <= '0;
        end else begin
            mode_q  <= mode_d;
            light_q <= light_d;
            idle_q  <= idle_d;
            presc_q <= presc_d;
        end
    end

    assign manual_override = (mode_q == MODE_MANUAL);
    assign manual_state    = light_q;
    assign idle_secs_left  = idle_q;

endmodule

// File: tb/tb_manual_override_panel.sv
// Bench for manual_override_panel: directed vector table, a mid-press reset sequence,
// and random button traffic checked against a cycle-level behavioural model.
module tb_manual_override_panel;

    localparam int D  = 4;
    localparam int TK = 10;
    localparam int TS = 3;
    localparam int HW = D + 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_next = 1'b0;
    logic       btn_red = 1'b0;
    logic       ov;
    logic [1:0] st;
    logic [7:0] idle;

    always #5 clk = ~clk;

    manual_override_panel #(
        .DEBOUNCE_CYCLES(D),
        .TICK_CYCLES(TK),
        .TIMEOUT_S(TS)
    ) dut (
        .clk(clk),
        .reset(rst),
        .btn_mode(btn_mode),
        .btn_next(btn_next),
        .btn_red(btn_red),
        .manual_override(ov),
        .manual_state(st),
        .idle_secs_left(idle)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: raw samples history, debounced level per button,
    // and the idle timer expressed as cycles elapsed since the last reload.
    bit m_hist [3][HW];
    bit m_deb  [3];
    bit m_rose [3];
    bit m_manual;
    int m_light;
    int m_since;

    function automatic int next_light(input int l);
        if (l == 0) return 2;
        if (l == 2) return 1;
        return 0;
    endfunction

    function automatic int exp_idle();
        if (!m_manual) return 0;
        return TS - m_since / TK;
    endfunction

    task automatic model_clear();
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < HW; k++) m_hist[b][k] = 1'b0;
            m_deb[b]  = 1'b0;
            m_rose[b] = 1'b0;
        end
        m_manual = 1'b0;
        m_light  = 0;
        m_since  = 0;
    endtask

    // Advances the model across one rising clock edge; r = {red, next, mode}.
    task automatic model_step(input bit rst_now, input logic [2:0] r);
        bit all_diff;
        if (rst_now) begin
            model_clear();
        end else begin
            if (m_manual) begin
                if (m_rose[2]) begin
                    m_light = 0;
                    m_since = 0;
                end else if (m_rose[0]) begin
                    m_manual = 1'b0;
                    m_light  = 0;
                end else if (m_rose[1]) begin
                    m_light = next_light(m_light);
                    m_since = 0;
                end else begin
                    m_since++;
                    if (TS != 0 && m_since == TS * TK) begin
                        m_manual = 1'b0;
                        m_light  = 0;
                    end
                end
            end else if (m_rose[2] || m_rose[0]) begin
                m_manual = 1'b1;
                m_light  = 0;
                m_since  = 0;
            end
            for (int b = 0; b < 3; b++) begin
                for (int k = HW - 1; k > 0; k--) m_hist[b][k] = m_hist[b][k-1];
                m_hist[b][0] = r[b];
                all_diff = 1'b1;
                for (int k = 2; k < D + 2; k++) begin
                    if (m_hist[b][k] == m_deb[b]) all_diff = 1'b0;
                end
                m_rose[b] = 1'b0;
                if (all_diff) begin
                    m_deb[b]  = ~m_deb[b];
                    m_rose[b] = m_deb[b];
                end
            end
        end
    endtask

    task automatic check_model();
        check("model_override", int'(ov), int'(m_manual));
        check("model_state", int'(st), m_light);
        check("model_idle", int'(idle), exp_idle());
        check("state_legal", int'(st != 2'b11), 1);
    endtask

    task automatic cycle(input logic [2:0] r);
        btn_mode = r[0];
        btn_next = r[1];
        btn_red  = r[2];
        model_step(rst, r);
        @(negedge clk);
        check_model();
    endtask

    typedef struct {
        logic [2:0] btn;
        int         cycles;
        logic       ov;
        logic [1:0] st;
        logic [7:0] idle;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [2:0] b, input int n, input logic o, input logic [1:0] s,
                       input logic [7:0] i);
        vec_t v;
        v.btn = b; v.cycles = n; v.ov = o; v.st = s; v.idle = i;
        vecs.push_back(v);
    endtask

    initial begin
        int hold [3];
        logic [2:0] val;
        logic [2:0] r;
        int quiet;

        // Idle after reset
        add(3'b000, 200, 1'b0, 2'd0, 8'd0);
        // Mode press: exact latency, then timer running
        add(3'b001, 6, 1'b0, 2'd0, 8'd0);
        add(3'b001, 1, 1'b1, 2'd0, 8'd3);
        add(3'b001, 13, 1'b1, 2'd0, 8'd2);
        add(3'b000, 4, 1'b1, 2'd0, 8'd2);
        // Three next presses: green, yellow, red, each reloading the timer
        add(3'b010, 10, 1'b1, 2'd2, 8'd3);
        add(3'b000, 10, 1'b1, 2'd2, 8'd2);
        add(3'b010, 10, 1'b1, 2'd1, 8'd3);
        add(3'b000, 10, 1'b1, 2'd1, 8'd2);
        add(3'b010, 10, 1'b1, 2'd0, 8'd3);
        add(3'b000, 10, 1'b1, 2'd0, 8'd2);
        // Countdown to auto-return
        add(3'b000, 6, 1'b1, 2'd0, 8'd2);
        add(3'b000, 1, 1'b1, 2'd0, 8'd1);
        add(3'b000, 9, 1'b1, 2'd0, 8'd1);
        add(3'b000, 1, 1'b0, 2'd0, 8'd0);
        // Next ignored in AUTO
        add(3'b010, 20, 1'b0, 2'd0, 8'd0);
        add(3'b000, 10, 1'b0, 2'd0, 8'd0);
        // Back to MANUAL, then a short glitch that must not register
        add(3'b001, 7, 1'b1, 2'd0, 8'd3);
        add(3'b000, 10, 1'b1, 2'd0, 8'd2);
        add(3'b010, 3, 1'b1, 2'd0, 8'd2);
        add(3'b000, 5, 1'b1, 2'd0, 8'd2);
        // Green, then red+mode together: red wins, stays MANUAL
        add(3'b010, 10, 1'b1, 2'd2, 8'd3);
        add(3'b000, 10, 1'b1, 2'd2, 8'd2);
        add(3'b101, 10, 1'b1, 2'd0, 8'd3);
        add(3'b000, 10, 1'b1, 2'd0, 8'd2);
        add(3'b010, 10, 1'b1, 2'd2, 8'd3);

        model_clear();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_override", int'(ov), 0);
        check("reset_state", int'(st), 0);
        check("reset_idle", int'(idle), 0);

        for (int i = 0; i < vecs.size(); i++) begin
            repeat (vecs[i].cycles) cycle(vecs[i].btn);
            check($sformatf("vec%0d_override", i), int'(ov), int'(vecs[i].ov));
            check($sformatf("vec%0d_state", i), int'(st), int'(vecs[i].st));
            check($sformatf("vec%0d_idle", i), int'(idle), int'(vecs[i].idle));
        end

        // Reset in the middle of a red press while showing green
        repeat (3) cycle(3'b100);
        #2 rst = 1'b1;
        #1;
        model_clear();
        check("midreset_override", int'(ov), 0);
        check("midreset_state", int'(st), 0);
        check("midreset_idle", int'(idle), 0);
        @(negedge clk);
        check_model();
        repeat (2) cycle(3'b100);
        rst = 1'b0;
        repeat (6) cycle(3'b100);
        check("redetect_before", int'(ov), 0);
        cycle(3'b100);
        check("redetect_override", int'(ov), 1);
        check("redetect_state", int'(st), 0);
        check("redetect_idle", int'(idle), 3);
        repeat (10) cycle(3'b000);

        // Random button traffic with occasional quiet spells to reach timeouts
        for (int b = 0; b < 3; b++) hold[b] = 0;
        val = 3'b000;
        quiet = 0;
        for (int n = 0; n < 4000; n++) begin
            for (int b = 0; b < 3; b++) begin
                if (hold[b] == 0) begin
                    val[b]  = ($urandom_range(0, 3) == 0);
                    hold[b] = $urandom_range(1, 14);
                end
                hold[b]--;
            end
            if (quiet == 0 && $urandom_range(0, 149) == 0) quiet = 45;
            r = val;
            if (quiet > 0) begin
                r = 3'b000;
                quiet--;
            end
            cycle(r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
